multicycle_adder_ctrl: RTL

Sequencer that performs a TOTAL_WIDTH-bit addition by time-multiplexing one CHUNK_WIDTH-bit ripple-carry adder over NUM_CHUNKS = TOTAL_WIDTH/CHUNK_WIDTH cycles, least-significant chunk first. It carries the inter-chunk carry in a register. It sits between a producer and a consumer with valid/ready handshakes on both sides. It trades latency for area when wide operands would otherwise need a full-width adder.

---
 rtl/mcadd_pkg.sv | 26 ++
 rtl/multicycle_adder_ctrl_if.sv | 36 +++
 rtl/ripple_carry_adder.sv | 25 ++
 rtl/multicycle_adder_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mcadd_pkg.sv
// Shared types and parameter helpers for the chunked multi-cycle adder.
package mcadd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned num_chunks(input int unsigned total_width,
                                             input int unsigned chunk_width);
    return total_width / chunk_width;
  endfunction

  // One spare bit so the counter can represent NUM_CHUNKS itself, even for NUM_CHUNKS = 1.
  function automatic int unsigned cnt_width(input int unsigned n_chunks);
    return $clog2(n_chunks) + 1;
  endfunction

  function automatic bit params_legal(input int unsigned total_width,
                                      input int unsigned chunk_width);
    return (chunk_width != 0) && (total_width >= chunk_width) &&
           ((total_width % chunk_width) == 0);
  endfunction

endpackage

// File: rtl/multicycle_adder_ctrl_if.sv
// Producer/consumer handshake bundle for multicycle_adder_ctrl.
// MCADD_SUB_EN adds the in_sub operand qualifier.
interface multicycle_adder_ctrl_if #(
  parameter int unsigned TOTAL_WIDTH = 128
);
  logic                   in_valid;
  logic                   in_ready;
  logic [TOTAL_WIDTH-1:0] in_a;
  logic [TOTAL_WIDTH-1:0] in_b;
  logic                   in_carry;
`ifdef MCADD_SUB_EN
  logic                   in_sub;
`endif
  logic                   out_valid;
  logic                   out_ready;
  logic [TOTAL_WIDTH-1:0] out_sum;
  logic                   out_carry;
  logic                   busy;

  modport master (
`ifdef MCADD_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_carry, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy
  );

  modport slave (
`ifdef MCADD_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_carry, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy
  );

endinterface

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder slice with carry in and carry out.
module ripple_carry_adder #(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0] a_i,
  input  logic [BIT_WIDTH-1:0] b_i,
  input  logic                 carry_in_i,
  output logic [BIT_WIDTH-1:0] sum_o,
  output logic                 carry_out_o
);

  logic [BIT_WIDTH:0] c;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    c[0] = carry_in_i;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign carry_out_o = c[BIT_WIDTH];

endmodule

// File: rtl/multicycle_adder_ctrl.sv
// Wide adder built from one CHUNK_WIDTH slice reused over NUM_CHUNKS cycles, LSB chunk first.
// Optional macro MCADD_SUB_EN: adds in_sub, computing A - B as A + ~B + 1.
module multicycle_adder_ctrl
  import mcadd_pkg::*;
#(
  parameter int unsigned TOTAL_WIDTH = 128,
  parameter int unsigned CHUNK_WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_adder_ctrl_if.slave bus
);

  localparam int unsigned NumChunks = num_chunks(TOTAL_WIDTH, CHUNK_WIDTH);
  localparam int unsigned CntWidth  = cnt_width(NumChunks);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumChunks - 1);

  if (!params_legal(TOTAL_WIDTH, CHUNK_WIDTH)) begin : g_param_check
    $error("TOTAL_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [TOTAL_WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic [TOTAL_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                   out_carry_q, out_carry_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [CHUNK_WIDTH-1:0] chunk_sum;
  logic                   chunk_carry;

  ripple_carry_adder #(
    .BIT_WIDTH (CHUNK_WIDTH)
  ) u_adder (
    .a_i         (a_q[CHUNK_WIDTH-1:0]),
    .b_i         (b_q[CHUNK_WIDTH-1:0]),
    .carry_in_i  (carry_q),
    .sum_o       (chunk_sum),
    .carry_out_o (chunk_carry)
  );

  // Next-state: operand capture, per-chunk shift, result publish and handshake flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_carry;
`ifdef MCADD_SUB_EN
          if (bus.in_sub) begin
            b_d     = ~bus.in_b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK_WIDTH;
        b_d     = b_q >> CHUNK_WIDTH;
        // New chunk enters at the top; after NUM_CHUNKS shifts it sits in its final place.
        sum_d   = (sum_q >> CHUNK_WIDTH) |
                  (TOTAL_WIDTH'(chunk_sum) << (TOTAL_WIDTH - CHUNK_WIDTH));
        carry_d = chunk_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          out_sum_d   = sum_d;
          out_carry_d = chunk_carry;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flags come straight from the next state so the ports are plain flop outputs.
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_carry = out_carry_q;
  assign bus.busy      = busy_q;

endmodule
